stepper_phase_decoder: RTL and testbench

//  Receive-side counterpart of the stepper sequencer. Watches the 4 one-hot coil drive lines,

---
 rtl/stepper_phase_decoder_pkg.sv | 44 ++++
 rtl/stepper_phase_decoder_filter.sv | 49 ++++
 rtl/stepper_phase_decoder.sv | 109 ++++++++++
 tb/tb_stepper_phase_decoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_phase_decoder_pkg.sv
// Shared definitions for the stepper coil decoder: coil one-hot constants
// (common with the sequencer), phase index type, FSM states and coil decode.
package stepper_phase_decoder_pkg;

    localparam logic [3:0] COIL_OFF = 4'b0000;
    localparam logic [3:0] COIL_PH0 = 4'b0001;
    localparam logic [3:0] COIL_PH1 = 4'b0010;
    localparam logic [3:0] COIL_PH2 = 4'b0100;
    localparam logic [3:0] COIL_PH3 = 4'b1000;

    typedef logic [1:0] phase_t;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Classified coil value: off, a legal single phase, or neither (illegal).
    typedef struct packed {
        logic   off;
        logic   legal;
        phase_t phase;
    } coil_dec_t;

    function automatic coil_dec_t decode_coil(input logic [3:0] c);
        coil_dec_t d;
        d = '0;
        case (c)
            COIL_OFF: d.off = 1'b1;
            COIL_PH0: begin d.legal = 1'b1; d.phase = 2'd0; end
            COIL_PH1: begin d.legal = 1'b1; d.phase = 2'd1; end
            COIL_PH2: begin d.legal = 1'b1; d.phase = 2'd2; end
            COIL_PH3: begin d.legal = 1'b1; d.phase = 2'd3; end
            default:  d = '0;
        endcase
        return d;
    endfunction

    // Forward distance from old to new phase, modulo 4.
    function automatic phase_t phase_delta(input phase_t p_old, input phase_t p_new);
        return p_new - p_old;
    endfunction

endpackage

// File: rtl/stepper_phase_decoder_filter.sv
// Coil glitch filter: a value must be sampled FILTER_CYCLES times in a row
// and differ from the previously accepted value to be accepted (one strobe).
module coil_glitch_filter #(
    parameter int WIDTH         = 4,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] value,
    output logic             accept
);

    localparam int CW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] din_r;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_d;
    logic             same;
    logic             hit;

    // Run-length count of identical samples; saturates so a run fires only once.
    always_comb begin
        same  = (din == din_r);
        cnt_d = CNT_ONE;
        if (same)
            cnt_d = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        hit = (cnt_d == CNT_MAX) && !(same && cnt == CNT_MAX) && (din != value);
    end

    // Sample register, counter and accepted-value register.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_r  <= '0;
            cnt    <= '0;
            value  <= '0;
            accept <= 1'b0;
        end else begin
            din_r  <= din;
            cnt    <= cnt_d;
            accept <= hit;
            if (hit)
                value <= din;
        end
    end

endmodule

// File: rtl/stepper_phase_decoder.sv
// Stepper phase decoder: filters the coil lines and turns legal phase
// advances into step pulses, direction and a wrapping signed position.
module stepper_phase_decoder
    import stepper_phase_decoder_pkg::*;
#(
    parameter int POS_WIDTH     = 16,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           coil,
    input  logic                 clr,
    output logic                 step_pulse,
    output logic                 step_dir,
    output logic [POS_WIDTH-1:0] position,
    output logic                 energised,
    output logic                 err_skip,
    output logic                 err_illegal
);

    localparam logic [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

    logic [3:0]           acc_value;
    logic                 acc_strobe;
    coil_dec_t            dec;
    phase_t               delta;

    state_t               state_q, state_d;
    phase_t               phase_q, phase_d;
    logic [POS_WIDTH-1:0] pos_d;
    logic                 dir_d, pulse_d, skip_d, ill_d;

    coil_glitch_filter #(
        .WIDTH         (4),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .din    (coil),
        .value  (acc_value),
        .accept (acc_strobe)
    );

    assign dec       = decode_coil(acc_value);
    assign delta     = phase_delta(phase_q, dec.phase);
    assign energised = (state_q == TRACK);

    // Next state and outputs; clr zeroes position/flags before any accepted
    // event is applied so a same-cycle step lands at +/-1.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        dir_d   = step_dir;
        pulse_d = 1'b0;
        pos_d   = clr ? '0 : position;
        skip_d  = clr ? 1'b0 : err_skip;
        ill_d   = clr ? 1'b0 : err_illegal;
        if (acc_strobe) begin
            if (dec.off) begin
                state_d = IDLE;
            end else if (!dec.legal) begin
                ill_d = 1'b1;
            end else if (state_q == IDLE) begin
                state_d = TRACK;
                phase_d = dec.phase;
                if (dec.phase != 2'd0)
                    skip_d = 1'b1;
            end else begin
                phase_d = dec.phase;
                case (delta)
                    2'd1: begin
                        pulse_d = 1'b1;
                        dir_d   = 1'b1;
                        pos_d   = pos_d + POS_ONE;
                    end
                    2'd3: begin
                        pulse_d = 1'b1;
                        dir_d   = 1'b0;
                        pos_d   = pos_d - POS_ONE;
                    end
                    2'd2:    skip_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // State, phase and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= 2'd0;
            step_pulse  <= 1'b0;
            step_dir    <= 1'b0;
            position    <= '0;
            err_skip    <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            step_pulse  <= pulse_d;
            step_dir    <= dir_d;
            position    <= pos_d;
            err_skip    <= skip_d;
            err_illegal <= ill_d;
        end
    end

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Bench for stepper_phase_decoder: directed scenarios plus randomized coil
// sequences, checked against a step-level reference model.
module tb_stepper_phase_decoder;

    localparam int FC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  coil = 4'b0000;
    logic        clr = 1'b0;

    logic        a_pulse, a_dir, a_en, a_skip, a_ill;
    logic [15:0] a_pos;
    logic        b_pulse, b_dir, b_en, b_skip, b_ill;
    logic [3:0]  b_pos;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int         m_pos;
    bit         m_track;
    int         m_p;
    bit         m_dir, m_skip, m_ill;
    logic [3:0] m_acc;
    int         last_first;

    always #5 clk = ~clk;

    stepper_phase_decoder #(.POS_WIDTH(16), .FILTER_CYCLES(FC)) u_dut16 (
        .clk(clk), .rst(rst), .coil(coil), .clr(clr),
        .step_pulse(a_pulse), .step_dir(a_dir), .position(a_pos),
        .energised(a_en), .err_skip(a_skip), .err_illegal(a_ill)
    );

    stepper_phase_decoder #(.POS_WIDTH(4), .FILTER_CYCLES(FC)) u_dut4 (
        .clk(clk), .rst(rst), .coil(coil), .clr(clr),
        .step_pulse(b_pulse), .step_dir(b_dir), .position(b_pos),
        .energised(b_en), .err_skip(b_skip), .err_illegal(b_ill)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_track = 0; m_p = 0;
        m_dir = 0; m_skip = 0; m_ill = 0;
        m_acc = 4'b0000;
    endtask

    // Apply one accepted coil value to the model; returns expected pulse count.
    task automatic model_accept(input logic [3:0] v, output int pulses);
        int p, d;
        pulses = 0;
        if (v == 4'b0000) begin
            m_track = 0;
        end else if ($countones(v) != 1) begin
            m_ill = 1;
        end else begin
            p = 0;
            for (int i = 0; i < 4; i++) if (v[i]) p = i;
            if (!m_track) begin
                m_track = 1;
                m_p = p;
                if (p != 0) m_skip = 1;
            end else begin
                d = (p - m_p + 4) % 4;
                if (d == 1) begin pulses = 1; m_dir = 1; m_pos++; end
                else if (d == 3) begin pulses = 1; m_dir = 0; m_pos--; end
                else if (d == 2) m_skip = 1;
                m_p = p;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".pos16"}, 32'(a_pos), 32'(m_pos & 32'hFFFF));
        chk({tag, ".pos4"},  32'(b_pos), 32'(m_pos & 32'hF));
        chk({tag, ".dir"},   32'(a_dir), 32'(m_dir));
        chk({tag, ".en"},    32'(a_en),  32'(m_track));
        chk({tag, ".skip"},  32'(a_skip), 32'(m_skip));
        chk({tag, ".ill"},   32'(a_ill),  32'(m_ill));
    endtask

    // Drive v for n cycles; clr_at>=0 raises clr for the edge at which an
    // acceptance in this hold takes effect (clr_at = FC).
    task automatic hold(input string tag, input logic [3:0] v, input int n, input int clr_at);
        int seen4, seen16, exp_p;
        bit accepted;
        seen4 = 0; seen16 = 0; last_first = -1;
        coil = v;
        for (int i = 0; i < n; i++) begin
            if (i == clr_at) clr = 1'b1;
            @(posedge clk); #1;
            clr = 1'b0;
            if (a_pulse) begin
                seen16++;
                if (last_first < 0) last_first = i;
            end
            if (b_pulse) seen4++;
        end
        accepted = (n >= FC) && (v != m_acc);
        if (clr_at >= 0 && clr_at < n) begin
            m_pos = 0; m_skip = 0; m_ill = 0;
        end
        exp_p = 0;
        if (accepted) begin
            m_acc = v;
            model_accept(v, exp_p);
        end
        chk({tag, ".pulse16"}, 32'(seen16), 32'(exp_p));
        chk({tag, ".pulse4"},  32'(seen4),  32'(exp_p));
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1; coil = 4'b0000; clr = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        m_pos = 0; m_skip = 0; m_ill = 0;
        check_outputs("clr");
    endtask

    initial begin
        logic [3:0] prev, v;
        int n, ca;

        // Reset state
        do_reset();
        chk("rst.pulse", 32'(a_pulse), 32'd0);
        check_outputs("rst");

        // Forward sequence, with exact pulse latency on the first step
        hold("fwd0", 4'b0001, 8, -1);
        hold("fwd1", 4'b0010, 8, -1);
        chk("fwd1.latency", 32'(last_first), 32'(FC));
        hold("fwd2", 4'b0100, 8, -1);
        hold("fwd3", 4'b1000, 8, -1);
        hold("fwd4", 4'b0001, 8, -1);
        chk("fwd.pos", 32'(a_pos), 32'd4);

        // Reverse sequence
        do_reset();
        hold("rev0", 4'b0001, 8, -1);
        hold("rev1", 4'b1000, 8, -1);
        hold("rev2", 4'b0100, 8, -1);
        chk("rev.pos", 32'(a_pos), 32'hFFFE);

        // Glitch shorter than the filter
        hold("gl0", 4'b0010, FC - 1, -1);
        hold("gl1", 4'b0100, 8, -1);

        // Skip, illegal, resync and clear
        do_reset();
        hold("sk0", 4'b0001, 8, -1);
        hold("sk1", 4'b0100, 8, -1);
        hold("il0", 4'b0101, 8, -1);
        hold("il1", 4'b1000, 8, -1);
        do_clr();
        chk("clr.skip", 32'(a_skip), 32'd0);

        // Idle entry at a non-zero phase
        hold("off", 4'b0000, 8, -1);
        hold("ent", 4'b0100, 8, -1);

        // Wrap of the 4-bit counter
        do_reset();
        hold("wr0", 4'b0001, 6, -1);
        for (int k = 1; k <= 7; k++) hold("wrs", 4'b0001 << (k % 4), 6, -1);
        chk("wrap.pos7", 32'(b_pos), 32'd7);
        hold("wr8", 4'b0001, 6, -1);
        chk("wrap.neg8", 32'(b_pos), 32'h8);

        // clr in the same cycle as an accepted forward step
        do_reset();
        hold("cs0", 4'b0001, 8, -1);
        hold("cs1", 4'b0010, 8, -1);
        hold("cs2", 4'b0100, 8, -1);
        hold("cs3", 4'b1000, 8, FC);
        chk("clrstep.pos", 32'(a_pos), 32'd1);

        // Reset mid-run with a phase held, then re-entry from IDLE
        hold("mr0", 4'b0010, 8, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("mr.pulse", 32'(a_pulse), 32'd0);
        check_outputs("mrst");
        hold("mr1", 4'b0010, 8, -1);

        // Randomized coil sequences
        prev = coil;
        for (int t = 0; t < 300; t++) begin
            do begin
                case ($urandom % 10)
                    0, 1, 2, 3, 4, 5: v = 4'b0001 << ($urandom % 4);
                    6, 7:             v = 4'b0000;
                    default: begin
                        do v = 4'($urandom); while ($countones(v) < 2);
                    end
                endcase
            end while (v == prev);
            ca = -1;
            if ($urandom % 4 == 0) n = $urandom_range(1, FC - 1);
            else begin
                n = $urandom_range(FC + 1, FC + 5);
                if ($urandom % 8 == 0) ca = FC;
            end
            hold("rnd", v, n, ca);
            prev = v;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
